// File: rtl/mac_dot_engine.sv
// mac_dot_engine: LANES parallel multiply-accumulate lanes computing dot products of runtime length,
// with a three-stage (product, accumulate, output) valid/ready pipeline and optional output saturation.
module mac_dot_engine #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int MAX_K  = 64,
    parameter int SIGNED = 1,
    parameter int ACC_W  = 2*DATA_W+$clog2(MAX_K)+1,
    parameter int OUT_W  = ACC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(MAX_K+1)-1:0] cfg_len,
    input  logic                       cfg_sat,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DATA_W-1:0]    a_in,
    input  logic [LANES*DATA_W-1:0]    b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*OUT_W-1:0]     out_data,
    output logic [LANES-1:0]           out_sat
);
    localparam int CW = $clog2(MAX_K+1);
    localparam int PW = 2*DATA_W;
    localparam logic SX = (SIGNED != 0);

    logic [CW-1:0] cnt, len_r, len_eff;
    logic sat_r, sat_eff, first, last, accept, stall, load;
    logic v1, f1, l1, s1, done, s2;
    logic [LANES*OUT_W-1:0] red_data;
    logic [LANES-1:0] red_sat;

    assign first    = (cnt == '0);
    assign len_eff  = !first ? len_r :
                      (cfg_len == '0) ? CW'(1) :
                      (cfg_len > CW'(MAX_K)) ? CW'(MAX_K) : cfg_len;
    assign sat_eff  = first ? cfg_sat : sat_r;
    assign last     = (cnt + CW'(1)) == len_eff;
    // A finished accumulation may leave stage 2 only if the output register is empty or draining now.
    assign load     = done && (!out_valid || out_ready);
    assign stall    = done && !load;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {cnt, len_r, sat_r, v1, f1, l1, s1, done, s2} <= '0;
            {out_valid, out_data, out_sat} <= '0;
        end else begin
            if (accept) begin
                cnt <= last ? '0 : cnt + CW'(1);
                if (first) begin
                    len_r <= len_eff;
                    sat_r <= cfg_sat;
                end
            end
            if (!stall) begin
                v1   <= accept;
                f1   <= first;
                l1   <= last;
                s1   <= sat_eff;
                done <= v1 && l1;
                if (v1) s2 <= s1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= red_data;
                out_sat   <= red_sat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_sat   <= '0;
            end
        end
    end

    genvar i;
    for (i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] a, b;
        logic [PW-1:0] p, prod;
        logic [ACC_W-1:0] pe, acc, hu;
        logic signed [ACC_W-1:0] hs;
        logic fits;
        assign a  = a_in[i*DATA_W +: DATA_W];
        assign b  = b_in[i*DATA_W +: DATA_W];
        // Low 2*DATA_W bits of the product of extended operands are the exact signed/unsigned product.
        assign p  = {{DATA_W{SX & a[DATA_W-1]}}, a} * {{DATA_W{SX & b[DATA_W-1]}}, b};
        assign pe = {{(ACC_W-PW){SX & prod[PW-1]}}, prod};
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod <= '0;
                acc  <= '0;
            end else if (!stall) begin
                prod <= p;
                if (v1) acc <= f1 ? pe : acc + pe;
            end
        end
        // The value fits OUT_W when everything above the kept bits is pure sign (or zero) extension.
        assign hs   = $signed(acc) >>> (OUT_W-1);
        assign hu   = acc >> OUT_W;
        assign fits = SX ? (hs == '0 || hs == '1) : (hu == '0);
        assign red_sat[i] = !fits;
        assign red_data[i*OUT_W +: OUT_W] = (s2 && !fits) ?
            (SX ? {acc[ACC_W-1], {(OUT_W-1){!acc[ACC_W-1]}}} : {OUT_W{1'b1}}) : acc[OUT_W-1:0];
    end
endmodule

// File: tb/tb_mac_dot_engine.sv
// tb_mac_dot_engine: directed table plus randomized vectors against a dot-product reference model,
// run on a full-width instance and a 16-bit output instance sharing the same stimulus.
module tb_mac_dot_engine;
    localparam int DW = 16;
    localparam int LN = 4;
    localparam int MK = 64;
    localparam int CW = 7;
    localparam int AW = 39;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [CW-1:0] cfg_len = '0;
    logic cfg_sat = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [LN*DW-1:0] a_in = '0, b_in = '0;
    logic in_ready0, in_ready1, out_valid0, out_valid1;
    logic [LN*AW-1:0] out_data0;
    logic [LN*16-1:0] out_data1;
    logic [LN-1:0] out_sat0, out_sat1;

    always #5 clk = ~clk;

    mac_dot_engine u0 (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_sat(cfg_sat),
        .in_valid(in_valid), .in_ready(in_ready0), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
    );

    mac_dot_engine #(.OUT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_sat(cfg_sat),
        .in_valid(in_valid), .in_ready(in_ready1), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1)
    );

    typedef struct {
        int len; int sat;
        int a0[4]; int b0[4]; int a1[4]; int b1[4];
        longint e0; longint e1; int t0; int s0;
    } vec_t;
    typedef struct { longint v[LN]; bit sat; } res_t;

    int n_chk = 0, n_fail = 0, cyc = 0, drops = 0;
    bit watch = 1'b0, drv_done = 1'b0;
    int va[MK][LN], vb[MK][LN];
    res_t exp_q[$];
    int hs_cyc[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint s16(input int x);
        logic signed [15:0] t;
        t = x[15:0];
        return t;
    endfunction

    // Reference narrowing to 16 bits: returns {flag, data}.
    function automatic logic [16:0] red16(input longint v, input bit sat);
        logic f;
        logic [15:0] d;
        f = (v < -32768) || (v > 32767);
        d = v[15:0];
        if (f && sat) d = (v < 0) ? 16'h8000 : 16'h7fff;
        return {f, d};
    endfunction

    function automatic int rnd();
        return $urandom_range(1, 0) ? int'($urandom_range(65535, 0)) - 32768 : int'($urandom_range(20, 0)) - 10;
    endfunction

    task automatic clear_buf();
        for (int k = 0; k < MK; k++)
            for (int l = 0; l < LN; l++) begin
                va[k][l] = 0;
                vb[k][l] = 0;
            end
    endtask

    task automatic gen_rand(input int n);
        for (int k = 0; k < n; k++)
            for (int l = 0; l < LN; l++) begin
                va[k][l] = rnd();
                vb[k][l] = rnd();
            end
    endtask

    // Sends n beats from the buffers; later beats carry junk cfg values that must be ignored.
    task automatic send(input int n, input int cfg, input bit sat, input bit gap, input bit model);
        res_t r;
        int len, w;
        bit ok;
        len = (cfg == 0) ? 1 : (cfg > MK) ? MK : cfg;
        if (model) begin
            r.sat = sat;
            for (int l = 0; l < LN; l++) begin
                r.v[l] = 0;
                for (int k = 0; k < len; k++) r.v[l] += s16(va[k][l]) * s16(vb[k][l]);
            end
            exp_q.push_back(r);
        end
        for (int k = 0; k < n; k++) begin
            if (gap && $urandom_range(2, 0) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
            end
            in_valid = 1'b1;
            cfg_len = (k == 0) ? CW'(cfg) : CW'($urandom);
            cfg_sat = (k == 0) ? sat : ~sat;
            for (int l = 0; l < LN; l++) begin
                a_in[l*DW +: DW] = DW'(va[k][l]);
                b_in[l*DW +: DW] = DW'(vb[k][l]);
            end
            w = 0;
            do begin
                @(negedge clk);
                ok = in_ready0;
                @(posedge clk); #1;
                w++;
            end while (!ok && w < 2000);
            if (!ok) chk("beat accept timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid0 && n < 50) begin @(posedge clk); #1; n++; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin @(posedge clk); n++; end
        #1;
        chk("results drained", exp_q.size(), 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    logic [LN*AW-1:0] ev0;
    logic [LN*16-1:0] ev1;
    logic [LN-1:0] es1;
    logic [16:0] rr;
    res_t mr;

    always @(negedge clk) begin
        if (watch && !in_ready0) drops++;
        if (rst_n && out_valid0 && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected result", 1, 0);
            else begin
                mr = exp_q.pop_front();
                for (int l = 0; l < LN; l++) begin
                    ev0[l*AW +: AW] = mr.v[l][AW-1:0];
                    rr = red16(mr.v[l], mr.sat);
                    ev1[l*16 +: 16] = rr[15:0];
                    es1[l] = rr[16];
                end
                chk("result data", out_data0, ev0);
                chk("result sat", out_sat0, 0);
                chk("narrow valid", out_valid1, 1);
                chk("narrow data", out_data1, ev1);
                chk("narrow sat", out_sat1, es1);
                hs_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int n, len, ti, diff;
        longint ex;
        logic [LN*AW-1:0] held;
        tbl[0] = '{4, 0, '{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, 10, -20, 3}, '{2, -3, 4, 5}, 70, -97, 70, 0};
        tbl[1] = '{2, 1, '{32767, 32767, 0, 0}, '{32767, 32767, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
                   2147352578, 0, 32767, 1};
        tbl[2] = '{2, 0, '{32767, 32767, 0, 0}, '{32767, 32767, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
                   2147352578, 0, 2, 1};
        tbl[3] = '{2, 1, '{-32768, -32768, 0, 0}, '{32767, 32767, 0, 0}, '{1, 1, 0, 0}, '{2, 3, 0, 0},
                   -2147418112, 5, -32768, 1};
        tbl[4] = '{0, 0, '{-7, 0, 0, 0}, '{9, 0, 0, 0}, '{100, 0, 0, 0}, '{-300, 0, 0, 0}, -63, -30000, -63, 0};
        clear_buf();

        #2 rst_n = 1'b0;
        #2;
        chk("reset out_valid", out_valid0, 0);
        chk("reset out_data", out_data0, 0);
        chk("reset out_sat", out_sat0, 0);
        chk("reset in_ready", in_ready0, 1);
        chk("reset narrow data", out_data1, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            clear_buf();
            for (int k = 0; k < 4; k++) begin
                va[k][0] = tbl[t].a0[k]; vb[k][0] = tbl[t].b0[k];
                va[k][1] = tbl[t].a1[k]; vb[k][1] = tbl[t].b1[k];
            end
            len = (tbl[t].len == 0) ? 1 : tbl[t].len;
            send(len, tbl[t].len, tbl[t].sat[0], 1'b0, 1'b1);
            wait_out(n);
            chk($sformatf("table%0d latency", t), n, 2);
            ex = tbl[t].e0;
            chk($sformatf("table%0d lane0", t), out_data0[AW-1:0], ex[AW-1:0]);
            ex = tbl[t].e1;
            chk($sformatf("table%0d lane1", t), out_data0[2*AW-1:AW], ex[AW-1:0]);
            ti = tbl[t].t0;
            chk($sformatf("table%0d narrow lane0", t), out_data1[15:0], ti[15:0]);
            chk($sformatf("table%0d narrow flag0", t), out_sat1[0], tbl[t].s0[0]);
            chk($sformatf("table%0d wide flags", t), out_sat0, 0);
        end
        drain();

        hs_cyc.delete();
        drops = 0;
        watch = 1'b1;
        for (int v = 0; v < 2; v++) begin
            gen_rand(4);
            send(4, 4, v[0], 1'b0, 1'b1);
        end
        drain();
        watch = 1'b0;
        chk("b2b in_ready drops", drops, 0);
        chk("b2b result count", hs_cyc.size(), 2);
        diff = (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1;
        chk("b2b result spacing", diff, 4);

        gen_rand(MK);
        send(MK, MK + 5, 1'b0, 1'b0, 1'b1);
        wait_out(n);
        chk("maxk latency", n, 2);
        gen_rand(3);
        send(3, 3, 1'b0, 1'b0, 1'b1);
        drain();

        out_ready = 1'b0;
        fork
            begin
                for (int v = 0; v < 3; v++) begin
                    gen_rand(4);
                    send(4, 4, 1'b0, 1'b0, 1'b1);
                end
            end
            begin
                n = 0;
                while (!out_valid0 && n < 200) begin @(negedge clk); n++; end
                chk("bp first result", out_valid0, 1);
                held = out_data0;
                n = 0;
                while (in_ready0 && n < 200) begin @(negedge clk); n++; end
                chk("bp stall", in_ready0, 0);
                repeat (3) @(negedge clk);
                chk("bp held data", out_data0, held);
                chk("bp held valid", out_valid0, 1);
                chk("bp still stalled", in_ready0, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        drv_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 20; v++) begin
                    len = $urandom_range(8, 1);
                    gen_rand(len);
                    send(len, (len == 1 && $urandom_range(1, 0) == 1) ? 0 : len, 1'($urandom_range(1, 0)), 1'b1, 1'b1);
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = 1'($urandom_range(1, 0));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        gen_rand(2);
        send(2, 2, 1'b0, 1'b0, 1'b1);
        wait_out(n);
        gen_rand(1);
        send(1, 4, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid0, 0);
        chk("midreset out_data", out_data0, 0);
        chk("midreset narrow data", out_data1, 0);
        chk("midreset in_ready", in_ready0, 1);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        clear_buf();
        va[0][0] = 1; va[1][0] = 1; vb[0][0] = 2; vb[1][0] = 3;
        send(2, 2, 1'b0, 1'b0, 1'b1);
        wait_out(n);
        chk("post-reset latency", n, 2);
        chk("post-reset lane0", out_data0[AW-1:0], 5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
